servo_ramp_ctrl: RTL and testbench



---
 rtl/servo_pkg.sv | 15 +
 rtl/servo_ramp_ctrl_if.sv | 17 +
 rtl/servo_ramp_ctrl_step_tick.sv | 34 +++
 rtl/servo_ramp_ctrl.sv | 142 ++++++++++++++
 tb/tb_servo_ramp_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared constants and types for the servo command/ramp logic.
//   ANGLE_W           - width of a servo angle / rotation value (8 bits)
//   FRAME_TICKS_50MHZ - clocks in one 20 ms PWM frame at 50 MHz
//   servo_state_e     - ramp controller FSM state encoding
package servo_pkg;

  localparam int ANGLE_W           = 8;
  localparam int FRAME_TICKS_50MHZ = 1000000;

  typedef enum logic {
    S_IDLE = 1'b0,  // rotation equals target, tick counter held at 0
    S_RAMP = 1'b1   // stepping toward target once per tick period
  } servo_state_e;

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// servo_ramp_ctrl_if: target-angle command channel.
//   cmd_valid - producer offers cmd_angle
//   cmd_ready - consumer can take a command this cycle
//   cmd_angle - requested target angle, unsigned
// Handshake: a command transfers on every rising clk edge where cmd_valid
// and cmd_ready are both high; the producer holds cmd_angle stable while
// cmd_valid is high and not yet accepted.
interface servo_ramp_ctrl_if;
  import servo_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [ANGLE_W-1:0] cmd_angle;

  modport master (output cmd_valid, output cmd_angle, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_angle, output cmd_ready);
endinterface

// File: rtl/servo_ramp_ctrl_step_tick.sv
// servo_step_tick: free-running period counter 0..TICKS-1 that wraps,
// with synchronous clear and count enable. tc_o is high in the cycle the
// counter sits at TICKS-1 while enabled (one pulse per period).
//   clk, rst - clock, synchronous active-high reset (clears the count)
//   clr_i    - force count to 0 (wins over en_i)
//   en_i     - advance the count
//   tc_o     - terminal-count pulse
module servo_step_tick #(
  parameter int TICKS = servo_pkg::FRAME_TICKS_50MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int            CW   = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: accepts target angles and slews the PWM driver's
// rotation value toward the target by at most STEP_SIZE every STEP_TICKS.
//   clk, rst     - clock, synchronous active-high reset
//   cmd          - target command channel (slave side)
//   rotation     - current angle to the PWM driver
//   set_rotation - one-cycle load strobe, high the cycle after rotation moves
//   servo_enable - PWM enable, set by the first accepted command
//   busy         - FSM is ramping (rotation differs from target)
//   done         - one-cycle pulse when the target is reached
//   state_dbg    - current FSM state
// Build option: define SERVO_RAMP_LIMIT_EN to clamp accepted targets to
// [MIN_ANGLE, MAX_ANGLE].
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int STEP_TICKS  = FRAME_TICKS_50MHZ,
  parameter int STEP_SIZE   = 1,
  parameter int RESET_ANGLE = 128,
  parameter int MIN_ANGLE   = 0,
  parameter int MAX_ANGLE   = 255
) (
  input  logic               clk,
  input  logic               rst,
  servo_ramp_ctrl_if.slave   cmd,
  output logic [ANGLE_W-1:0] rotation,
  output logic               set_rotation,
  output logic               servo_enable,
  output logic               busy,
  output logic               done,
  output servo_state_e       state_dbg
);
  localparam logic [ANGLE_W-1:0] RESET_A = ANGLE_W'(RESET_ANGLE);
  localparam logic [ANGLE_W:0]   STEP_W  = (ANGLE_W + 1)'(STEP_SIZE);

  servo_state_e       state_q, state_d;
  logic [ANGLE_W-1:0] target_q, target_d;
  logic [ANGLE_W-1:0] rotation_q, rotation_d;
  logic               set_rot_q, set_rot_d;
  logic               done_q, done_d;
  logic               enable_q, enable_d;

  logic               accept, step, tick_tc;
  logic [ANGLE_W-1:0] cmd_tgt, rot_step, step_amt;
  logic signed [ANGLE_W:0] diff;
  logic [ANGLE_W:0]   mag;

  assign cmd.cmd_ready = !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

`ifdef SERVO_RAMP_LIMIT_EN
  localparam logic [ANGLE_W-1:0] MIN_A = ANGLE_W'(MIN_ANGLE);
  localparam logic [ANGLE_W-1:0] MAX_A = ANGLE_W'(MAX_ANGLE);

  always_comb begin
    cmd_tgt = cmd.cmd_angle;
    if (cmd.cmd_angle < MIN_A)      cmd_tgt = MIN_A;
    else if (cmd.cmd_angle > MAX_A) cmd_tgt = MAX_A;
  end
`else
  logic unused_limits;
  assign unused_limits = ^{ANGLE_W'(MIN_ANGLE), ANGLE_W'(MAX_ANGLE)};
  assign cmd_tgt       = cmd.cmd_angle;
`endif

  // The counter only advances while ramping and is cleared on the edge that
  // enters IDLE, so a fresh ramp always starts from 0 while a retarget
  // (state stays RAMP) keeps the step cadence.
  servo_step_tick #(.TICKS(STEP_TICKS)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_d == S_IDLE),
    .en_i  (state_q == S_RAMP),
    .tc_o  (tick_tc)
  );

  assign step = (state_q == S_RAMP) && tick_tc;

  // Step toward the registered target; limiting the move to |diff| means
  // the result can neither overshoot nor wrap.
  always_comb begin
    diff     = $signed({1'b0, target_q}) - $signed({1'b0, rotation_q});
    mag      = diff[ANGLE_W] ? $unsigned(-diff) : $unsigned(diff);
    step_amt = (mag < STEP_W) ? mag[ANGLE_W-1:0] : STEP_W[ANGLE_W-1:0];
    rot_step = diff[ANGLE_W] ? rotation_q - step_amt : rotation_q + step_amt;
  end

  // A step and an accept on the same edge: the step uses the old target,
  // and arrival is judged against the new one.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    rotation_d = rotation_q;
    set_rot_d  = 1'b0;
    done_d     = 1'b0;
    enable_d   = enable_q || accept;
    if (accept) target_d = cmd_tgt;
    if (step) begin
      rotation_d = rot_step;
      set_rot_d  = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_tgt != rotation_q) state_d = S_RAMP;
          else                       done_d  = 1'b1;
        end
      end
      S_RAMP: begin
        if (rotation_d == target_d) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      target_q   <= RESET_A;
      rotation_q <= RESET_A;
      set_rot_q  <= 1'b0;
      done_q     <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      rotation_q <= rotation_d;
      set_rot_q  <= set_rot_d;
      done_q     <= done_d;
      enable_q   <= enable_d;
    end
  end

  assign rotation     = rotation_q;
  assign set_rotation = set_rot_q;
  assign servo_enable = enable_q;
  assign busy         = (state_q == S_RAMP);
  assign done         = done_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb_servo_ramp_ctrl: directed bench for servo_ramp_ctrl. Two instances
// share clock and reset: u_dut1 (STEP_TICKS=4, STEP_SIZE=1, limits 20..200)
// and u_dut2 (STEP_TICKS=4, STEP_SIZE=10). Each event (strobe or done) is
// expected as {cycle, set_rotation, done, rotation}.
module tb_servo_ramp_ctrl;
  import servo_pkg::*;

  localparam int ST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  servo_ramp_ctrl_if if1 ();
  servo_ramp_ctrl_if if2 ();

  logic [7:0]   r1, r2;
  logic         s1, s2, e1, e2, b1, b2, d1, d2;
  servo_state_e st1, st2;

  servo_ramp_ctrl #(.STEP_TICKS(ST), .STEP_SIZE(1), .RESET_ANGLE(128),
                    .MIN_ANGLE(20), .MAX_ANGLE(200)) u_dut1 (
    .clk(clk), .rst(rst), .cmd(if1.slave), .rotation(r1), .set_rotation(s1),
    .servo_enable(e1), .busy(b1), .done(d1), .state_dbg(st1));

  servo_ramp_ctrl #(.STEP_TICKS(ST), .STEP_SIZE(10), .RESET_ANGLE(128),
                    .MIN_ANGLE(0), .MAX_ANGLE(255)) u_dut2 (
    .clk(clk), .rst(rst), .cmd(if2.slave), .rotation(r2), .set_rotation(s2),
    .servo_enable(e2), .busy(b2), .done(d2), .state_dbg(st2));

  // ---------------- scoreboard ----------------
  logic [41:0] exp_q1[$];
  logic [41:0] exp_q2[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [41:0] ev(int unsigned c, logic s, logic d, logic [7:0] r);
    return {c, s, d, r};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_cmp(input string name, input logic [41:0] act, inout logic [41:0] q[$]);
    logic [41:0] e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: got cyc=%0d strobe=%0b done=%0b rot=%0d, expected no event",
               name, act[41:10], act[9], act[8], act[7:0]);
    end else begin
      e = q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s_event: got cyc=%0d strobe=%0b done=%0b rot=%0d, expected cyc=%0d strobe=%0b done=%0b rot=%0d",
                 name, act[41:10], act[9], act[8], act[7:0], e[41:10], e[9], e[8], e[7:0]);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (s1 || d1) mon_cmp("dut1", {cyc, s1, d1, r1}, exp_q1);
    if (s2 || d2) mon_cmp("dut2", {cyc, s2, d2, r2}, exp_q2);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send1(input logic [7:0] angle, output int unsigned acc_cyc);
    if1.cmd_valid = 1'b1;
    if1.cmd_angle = angle;
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    if1.cmd_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] angle, output int unsigned acc_cyc);
    if2.cmd_valid = 1'b1;
    if2.cmd_angle = angle;
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    if2.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q1.delete();
    exp_q2.delete();
    tick(1);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q1.size() == 0 && exp_q2.size() == 0) break;
      tick(1);
    end
    check(name, exp_q1.size() + exp_q2.size(), 0);
  endtask

  // Hard stop if the sequence itself ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of sequence");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned a, b;
    int          lim_end;
    if1.cmd_valid = 1'b0; if1.cmd_angle = '0;
    if2.cmd_valid = 1'b0; if2.cmd_angle = '0;
    rst = 1'b1;
    tick(2);

    // Reset state
    check("rst_ready1",  int'(if1.cmd_ready), 0);
    check("rst_ready2",  int'(if2.cmd_ready), 0);
    check("rst_rot1",    int'(r1), 128);
    check("rst_strobe1", int'(s1), 0);
    check("rst_enable1", int'(e1), 0);
    check("rst_busy1",   int'(b1), 0);
    check("rst_done1",   int'(d1), 0);
    rst = 1'b0;
    tick(20);
    check("idle_rot1",    int'(r1), 128);
    check("idle_rot2",    int'(r2), 128);
    check("idle_strobe1", int'(s1), 0);
    check("idle_enable1", int'(e1), 0);
    check("idle_busy1",   int'(b1), 0);
    check("idle_ready1",  int'(if1.cmd_ready), 1);

    // 128 -> 131, step 1: three strobes every ST cycles, done with the last
    send1(8'd131, a);
    exp_q1.push_back(ev(a + 4,  1'b1, 1'b0, 8'd129));
    exp_q1.push_back(ev(a + 8,  1'b1, 1'b0, 8'd130));
    exp_q1.push_back(ev(a + 12, 1'b1, 1'b1, 8'd131));
    check("ramp_busy_rise", int'(b1), 1);
    check("ramp_enable",    int'(e1), 1);
    wait_drain("ramp_drain", 30);
    check("ramp_end_rot",  int'(r1), 131);
    check("ramp_end_busy", int'(b1), 0);

    // 128 -> 133, step 10: a single step limited by |diff|
    send2(8'd133, a);
    exp_q2.push_back(ev(a + 4, 1'b1, 1'b1, 8'd133));
    wait_drain("big_step_drain", 20);
    check("big_step_rot", int'(r2), 133);

    // 128 -> 140, retarget to 120 once rotation is 130
    do_reset();
    send1(8'd140, a);
    exp_q1.push_back(ev(a + 4, 1'b1, 1'b0, 8'd129));
    exp_q1.push_back(ev(a + 8, 1'b1, 1'b0, 8'd130));
    tick(8);
    send1(8'd120, b);
    check("retarget_accept_cyc", int'(b), int'(a + 9));
    for (int k = 1; k <= 10; k++)
      exp_q1.push_back(ev(a + 8 + 4 * k, 1'b1, (k == 10), 8'(130 - k)));
    wait_drain("retarget_drain", 80);
    check("retarget_rot",  int'(r1), 120);
    check("retarget_busy", int'(b1), 0);

    // Command equal to the current angle: done only, never busy
    do_reset();
    send1(8'd128, a);
    exp_q1.push_back(ev(a, 1'b0, 1'b1, 8'd128));
    check("equal_busy", int'(b1), 0);
    tick(3);
    check("equal_busy_later", int'(b1), 0);
    wait_drain("equal_drain", 10);
    check("equal_rot", int'(r1), 128);

    // Large command: clamped when the limit build is enabled
`ifdef SERVO_RAMP_LIMIT_EN
    lim_end = 200;
`else
    lim_end = 250;
`endif
    do_reset();
    send1(8'd250, a);
    for (int r = 129; r <= lim_end; r++)
      exp_q1.push_back(ev(a + 4 * (r - 128), 1'b1, (r == lim_end), 8'(r)));
    wait_drain("limit_drain", 4 * (lim_end - 128) + 20);
    check("limit_rot", int'(r1), lim_end);

    // Reset mid-ramp aborts with no strobe or done
    do_reset();
    send1(8'd140, a);
    exp_q1.push_back(ev(a + 4, 1'b1, 1'b0, 8'd129));
    exp_q1.push_back(ev(a + 8, 1'b1, 1'b0, 8'd130));
    tick(9);
    check("midrst_pre_drain", exp_q1.size(), 0);
    check("midrst_pre_busy",  int'(b1), 1);
    rst = 1'b1;
    #1;
    check("midrst_ready", int'(if1.cmd_ready), 0);
    tick(1);
    rst = 1'b0;
    check("midrst_rot",    int'(r1), 128);
    check("midrst_enable", int'(e1), 0);
    check("midrst_strobe", int'(s1), 0);
    check("midrst_busy",   int'(b1), 0);
    check("midrst_done",   int'(d1), 0);
    tick(12);
    check("midrst_quiet_rot",  int'(r1), 128);
    check("midrst_quiet_busy", int'(b1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
